// File: rtl/negate_seq_ctrl.sv
// -----------------------------------------------------------------------------
// negate_seq_ctrl
//   Byte-serial one's-complement / two's-complement negate engine. An accepted
//   operand is transformed one byte per cycle, least significant byte first,
//   with a ripple carry held between cycles. Latency is fixed at NBYTES RUN
//   cycles followed by a single DONE cycle.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   request strobe, only looked at while ready=1
//   mode       in   0 = bitwise NOT, 1 = two's-complement negate
//   operand    in   W-bit value to transform, captured on accept
//   ready      out  high only in IDLE
//   busy       out  high in RUN and DONE
//   done       out  one-cycle pulse, result and flags valid in that cycle
//   result     out  transformed value, held until next accept or reset
//   zero_flag  out  result == 0
//   ovf        out  negate of the most negative value (not representable)
// -----------------------------------------------------------------------------
module negate_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [8*NBYTES-1:0]   operand,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  zero_flag,
    output logic                  ovf
);

    localparam int unsigned W        = 8 * NBYTES;
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [W-1:0]        op_q, op_d;
    logic                mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [W-1:0]        result_q, result_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;

    logic                accept_c;
    logic                last_byte_c;
    logic [7:0]          op_byte_c;
    logic [8:0]          byte_sum_c;

    assign accept_c    = (state_q == S_IDLE) && start;
    assign last_byte_c = (idx_q == LAST_IDX);
    assign op_byte_c   = op_q[{idx_q, 3'b000} +: 8];
    // Ninth bit is the carry into the next byte; it is set only when the
    // inverted byte was 0xFF and a carry came in.
    assign byte_sum_c  = {1'b0, ~op_byte_c} + {8'd0, carry_q};

    // State and datapath registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c)    state_d = S_RUN;
            S_RUN:   if (last_byte_c) state_d = S_DONE;
            S_DONE:                   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered, so decode them from the next state.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN) || (state_d == S_DONE);
        done_d  = (state_d == S_DONE);
    end

    // Byte-serial datapath: capture on accept, one byte per RUN cycle.
    always_comb begin
        op_d     = op_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        if (accept_c) begin
            op_d     = operand;
            mode_d   = mode;
            idx_d    = '0;
            carry_d  = mode;
            result_d = '0;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == S_RUN) begin
            result_d[{idx_q, 3'b000} +: 8] = byte_sum_c[7:0];
            if (last_byte_c) begin
                // Carry out of the top byte is dropped: W-bit wrap-around.
                idx_d   = '0;
                carry_d = 1'b0;
                zero_d  = (result_d == '0);
                ovf_d   = mode_q && (op_q == MIN_NEG);
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                carry_d = byte_sum_c[8];
            end
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero_flag = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_negate_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_negate_seq_ctrl
//   Scoreboard bench: the driver pushes the expected response of each accepted
//   request (value from plain W-bit arithmetic, expected done cycle from the
//   fixed latency); an independent monitor pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_negate_seq_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    typedef struct {
        logic [W-1:0] res;
        logic         zf;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] operand;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero_flag;
    logic         ovf;

    exp_t         sb_q[$];
    int           vectors   = 0;
    int           miscomp   = 0;
    int           cyc       = 0;
    bit           mon_en    = 1'b0;
    logic [W-1:0] last_res;

    negate_seq_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .operand   (operand),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero_flag (zero_flag),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscomp++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: negate is 0 - x, NOT is ~x, both modulo 2^W.
    function automatic void push_exp(input bit m, input logic [W-1:0] op,
                                     input int done_cyc);
        exp_t e;
        e.res = m ? (W'(0) - op) : ~op;
        e.zf  = (e.res == '0);
        e.ovf = m && (op == (W'(1) << (W - 1)));
        e.cyc = done_cyc;
        sb_q.push_back(e);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (mon_en && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", W'(1), W'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result",    result,         e.res);
                check("zero_flag", W'(zero_flag),  W'(e.zf));
                check("ovf",       W'(ovf),        W'(e.ovf));
                check("latency",   W'(cyc),        W'(e.cyc));
                last_res = e.res;
            end
        end
    end

    // Wait (bounded) for ready at a falling edge.
    task automatic wait_ready();
        int guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) check("ready_timeout", W'(ready), W'(1));
    endtask

    // One operation; with junk=1 start is held high with a different operand
    // throughout RUN/DONE to prove it is ignored.
    task automatic do_op(input bit m, input logic [W-1:0] op, input bit junk);
        @(negedge clk);
        wait_ready();
        start   = 1'b1;
        mode    = m;
        operand = op;
        push_exp(m, op, cyc + 1 + NB);
        @(negedge clk);
        for (int i = 0; i <= NB; i++) begin
            start = junk;
            if (junk) begin
                operand = '1;
                mode    = 1'($urandom);
            end
            check("ready_low_busy", {ready, busy}, 2'b01);
            @(negedge clk);
        end
        start = 1'b0;
        check("idle_after_done", {ready, busy}, 2'b10);
        check("result_hold", result, last_res);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        operand = '0;
        last_res = '0;
        repeat (2) @(negedge clk);
        // Reset state; start asserted during reset must not be accepted.
        start = 1'b1;
        @(negedge clk);
        check("rst_outputs", {ready, busy, done, zero_flag, ovf}, 5'b10000);
        check("rst_result", result, '0);
        rst    = 1'b0;
        start  = 1'b0;
        mon_en = 1'b1;

        // Directed cases.
        do_op(1'b1, 32'h0000_0001, 1'b0);
        do_op(1'b0, 32'h1234_5678, 1'b0);
        do_op(1'b1, 32'h0001_0000, 1'b0);
        do_op(1'b1, 32'h0000_0000, 1'b0);
        do_op(1'b1, 32'h8000_0000, 1'b0);
        do_op(1'b0, 32'h8000_0000, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b1, 32'h0000_0005, 1'b1);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        wait_ready();
        start   = 1'b1;
        mode    = 1'b1;
        operand = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {ready, busy, done}, 3'b100);
        check("abort_result", result, '0);
        repeat (NB + 3) @(negedge clk);
        last_res = '0;
        do_op(1'b1, 32'h0000_00FF, 1'b0);

        // Random operations with a sprinkling of boundary operands.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] op;
            case ($urandom_range(0, 5))
                0:       op = '0;
                1:       op = 32'h8000_0000;
                2:       op = 32'hFFFF_FF00;
                default: op = $urandom;
            endcase
            do_op(1'($urandom), op, 1'($urandom));
        end

        // start held high: accepts must be exactly NB+2 cycles apart.
        begin
            int last = -1;
            int acc  = 0;
            int guard = 0;
            @(negedge clk);
            start = 1'b1;
            while (acc < 5 && guard < 200) begin
                mode    = 1'($urandom);
                operand = $urandom;
                if (ready === 1'b1) begin
                    push_exp(mode, operand, cyc + 1 + NB);
                    if (last >= 0) check("accept_spacing", W'(cyc - last), W'(NB + 2));
                    last = cyc;
                    acc++;
                end
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            if (acc < 5) check("stream_timeout", W'(acc), W'(5));
        end

        // Drain the scoreboard.
        begin
            int guard = 0;
            while (sb_q.size() != 0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("drain", W'(sb_q.size()), W'(0));
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule

// File: doc/negate_seq_ctrl.md
NEGATE_SEQ_CTRL -- requirements
Module: negate_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, meaning number of 8-bit bytes per operand; W = 8*NBYTES.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request strobe; sampled only while ready=1.
REQ-005 The block SHALL have port mode  input  1  operation: 0 = one's complement (bitwise NOT), 1 = two's-complement negate.
REQ-006 The block SHALL have port operand  input  W  value to transform; sampled on accept.
REQ-007 The block SHALL have port ready  output  1  high only in IDLE; a request is accepted when start=1 and ready=1.
REQ-008 The block SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; result and flags are valid in that cycle.
REQ-010 The block SHALL have port result  output  W  registered transformed value.
REQ-011 The block SHALL have port zero_flag  output  1  registered; result == 0.
REQ-012 The block SHALL have port ovf  output  1  registered; mode=1 and operand == 1<<(W-1) (negate not representable).

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on accept; RUN->DONE after byte NBYTES-1 is processed; DONE->IDLE unconditionally after one cycle.
REQ-014 On accept at edge T, the block SHALL latch operand and mode, clear result, zero_flag and ovf to 0, set the byte index to 0, and set carry to mode.
REQ-015 In RUN, each cycle SHALL process exactly one byte k, least significant first: result[8k+7:8k] = (~operand[8k+7:8k] + carry) mod 256.
REQ-016 The carry into byte k+1 SHALL be 1 only if the carry into byte k was 1 and ~operand[8k+7:8k] == 0xFF.
REQ-017 The final carry out of byte NBYTES-1 SHALL be discarded, giving W-bit wrap-around.
REQ-018 Latency SHALL be fixed: with accept at edge T, RUN occupies NBYTES cycles and done=1 in the cycle after edge T+NBYTES; it is independent of operand and mode.
REQ-019 zero_flag and ovf SHALL be registered on the RUN->DONE edge and SHALL hold, together with result, until the next accept or reset.
REQ-020 start SHALL be ignored in RUN and DONE; requests are not queued, and latched operand/mode SHALL NOT change mid-operation.
REQ-021 The earliest next accept SHALL be in the IDLE cycle following DONE, giving a throughput of one operation per NBYTES+2 cycles.
REQ-022 Boundary: mode=1, operand=0 SHALL propagate carry through all bytes, giving result 0, zero_flag 1, ovf 0.
REQ-023 Boundary: mode=0 SHALL never set ovf, and the carry SHALL remain 0 throughout.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL enter IDLE and set ready=1, busy=0, done=0, result=0, zero_flag=0, ovf=0, byte index 0 and carry 0.
REQ-025 rst SHALL take priority over start in the same cycle; no request is accepted while rst=1.
REQ-026 A reset during RUN or DONE SHALL abort the operation with no done pulse, and the partial result SHALL be cleared.

Verification
REQ-027 The bench SHALL cover: mode=1, operand 0x00000001 accepted at T -> done in the cycle after T+4, result 0xFFFFFFFF, zero_flag 0, ovf 0.
REQ-028 The bench SHALL cover: mode=0, operand 0x12345678 -> result 0xEDCBA987, ovf 0; mode=1, operand 0x00010000 -> result 0xFFFF0000, which checks inter-byte carry.
REQ-029 The bench SHALL cover: mode=1, operand 0x00000000 -> result 0x00000000, zero_flag 1, ovf 0; mode=1, operand 0x80000000 -> result 0x80000000, ovf 1.
REQ-030 The bench SHALL cover: start re-asserted with operand 0xFFFFFFFF during RUN of a mode=1, operand 0x00000005 operation -> ignored; result 0xFFFFFFFB; ready stays 0 until the IDLE cycle after done.
REQ-031 The bench SHALL cover: rst pulsed in the second RUN cycle -> after the next edge ready=1, busy=0, result=0, and no done pulse for the aborted operation; a fresh request then completes normally.
REQ-032 The bench SHALL cover: start held high continuously -> accepts spaced exactly NBYTES+2 cycles apart, with exactly one done pulse per accept.
